vec_demux3_buf: RTL and testbench

VEC_DEMUX3_BUF -- requirements
Module: vec_demux3_buf

---
 rtl/vec_demux3_buf.sv | 101 ++++++++++
 tb/tb_vec_demux3_buf.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_demux3_buf.sv
// Purpose: route one upstream vector to one of three single-entry output holding registers.
// Latency: 1 cycle from accept to out_valid/out_data on the selected port.
// Backpressure: in_ready follows the selected port only (empty or draining) and drops during flush.
module vec_demux3_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNTW  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [1:0]                    in_sel,
    input  logic [0:DEPTH-1][WIDTH-1:0]   in_data,
    output logic [2:0]                    out_valid,
    input  logic [2:0]                    out_ready,
    output logic [0:DEPTH-1][WIDTH-1:0]   out_data0,
    output logic [0:DEPTH-1][WIDTH-1:0]   out_data1,
    output logic [0:DEPTH-1][WIDTH-1:0]   out_data2,
    output logic [CNTW-1:0]               cnt0,
    output logic [CNTW-1:0]               cnt1,
    output logic [CNTW-1:0]               cnt2
);

    typedef logic [0:DEPTH-1][WIDTH-1:0] vec_t;

    logic [2:0]      dest;
    logic            accept;
    logic [2:0]      xfer;
    logic [2:0]      valid_q;
    vec_t            data_q [3];
    logic [CNTW-1:0] cnt_q  [3];

    // One-hot destination decode; in_sel[1] wins so 10 and 11 both pick port2.
    always_comb begin
        dest = 3'b001;
        if (in_sel[1]) begin
            dest = 3'b100;
        end else if (in_sel[0]) begin
            dest = 3'b010;
        end
    end

    // Upstream ready depends only on the selected port's state, never on in_valid.
    always_comb begin
        in_ready = (|(dest & (~valid_q | out_ready))) && !flush;
        accept   = in_valid && in_ready;
        xfer     = valid_q & out_ready;
    end

    // Valid bits: drain clears, accept sets (accept wins so drain+reload has no bubble).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 3'b000;
        end else if (flush) begin
            valid_q <= 3'b000;
        end else begin
            valid_q <= (valid_q & ~xfer) | (accept ? dest : 3'b000);
        end
    end

    // Holding registers load only on an accept into that port; otherwise they hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < 3; n++) begin
                data_q[n] <= '0;
            end
        end else begin
            for (int n = 0; n < 3; n++) begin
                if (accept && dest[n]) begin
                    data_q[n] <= in_data;
                end
            end
        end
    end

    // Transfer counters wrap naturally; a flush edge does not count drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < 3; n++) begin
                cnt_q[n] <= '0;
            end
        end else if (!flush) begin
            for (int n = 0; n < 3; n++) begin
                if (xfer[n]) begin
                    cnt_q[n] <= cnt_q[n] + CNTW'(1);
                end
            end
        end
    end

    assign out_valid = valid_q;
    assign out_data0 = data_q[0];
    assign out_data1 = data_q[1];
    assign out_data2 = data_q[2];
    assign cnt0      = cnt_q[0];
    assign cnt1      = cnt_q[1];
    assign cnt2      = cnt_q[2];

endmodule

// File: tb/tb_vec_demux3_buf.sv
module tb_vec_demux3_buf;

    localparam int W = 32;
    localparam int D = 4;
    localparam int C = 16;

    typedef logic [0:D-1][W-1:0] vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [1:0]   in_sel = 2'b00;
    vec_t         in_data = '0;
    logic [2:0]   out_valid;
    logic [2:0]   out_ready = 3'b000;
    vec_t         out_data0, out_data1, out_data2;
    logic [C-1:0] cnt0, cnt1, cnt2;

    int total = 0;
    int bad   = 0;

    // Reference model: each port is a capacity-1 queue plus the last vector loaded.
    vec_t pq [3][$];
    vec_t last_vec [3];
    int   m_cnt [3];

    vec_t va, vb, vc, vtmp;
    int   saved [3];

    vec_t obs_data [3];
    logic [C-1:0] obs_cnt [3];

    always #5 clk = ~clk;

    vec_demux3_buf #(.WIDTH(W), .DEPTH(D), .CNTW(C)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data0 (out_data0),
        .out_data1 (out_data1),
        .out_data2 (out_data2),
        .cnt0      (cnt0),
        .cnt1      (cnt1),
        .cnt2      (cnt2)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int port_of(input logic [1:0] sel);
        if (sel == 2'b00) return 0;
        if (sel == 2'b01) return 1;
        return 2;
    endfunction

    function automatic bit model_ready();
        int d;
        d = port_of(in_sel);
        return ((pq[d].size() == 0) || out_ready[d]) && !flush;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        for (int i = 0; i < D; i++) v[i] = $urandom;
        return v;
    endfunction

    task automatic model_reset();
        for (int n = 0; n < 3; n++) begin
            pq[n].delete();
            last_vec[n] = '0;
            m_cnt[n] = 0;
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [2:0] mv;
        obs_data[0] = out_data0; obs_data[1] = out_data1; obs_data[2] = out_data2;
        obs_cnt[0] = cnt0; obs_cnt[1] = cnt1; obs_cnt[2] = cnt2;
        for (int n = 0; n < 3; n++) mv[n] = (pq[n].size() != 0);
        check({tag, "_valid"}, 128'(out_valid), 128'(mv));
        for (int n = 0; n < 3; n++) begin
            check($sformatf("%s_data%0d", tag, n), obs_data[n], last_vec[n]);
            check($sformatf("%s_cnt%0d", tag, n), 128'(obs_cnt[n]), 128'(m_cnt[n]));
        end
    endtask

    // One clock: check in_ready, advance the model at the edge, then check outputs.
    task automatic tick(input string tag);
        bit rdy, acc;
        int d;
        #1;
        rdy = model_ready();
        d   = port_of(in_sel);
        acc = in_valid && rdy;
        check({tag, "_in_ready"}, 128'(in_ready), 128'(rdy));
        @(posedge clk);
        if (flush) begin
            for (int n = 0; n < 3; n++) pq[n].delete();
        end else begin
            for (int n = 0; n < 3; n++) begin
                if (pq[n].size() != 0 && out_ready[n]) begin
                    vtmp = pq[n].pop_front();
                    m_cnt[n] = (m_cnt[n] + 1) % (1 << C);
                end
            end
            if (acc) begin
                pq[d].push_back(in_data);
                last_vec[d] = in_data;
            end
        end
        #1;
        check_outputs(tag);
    endtask

    task automatic drive(input bit v, input logic [1:0] s, input vec_t dat, input logic [2:0] ordy, input bit f);
        in_valid  = v;
        in_sel    = s;
        in_data   = dat;
        out_ready = ordy;
        flush     = f;
    endtask

    initial begin
        int guard;
        model_reset();
        va[0] = 32'h11; va[1] = 32'h22; va[2] = 32'h33; va[3] = 32'h44;
        vb = rand_vec();
        vc = rand_vec();

        // Reset state
        #12;
        check_outputs("reset");
        rst_n = 1'b1;
        #1;
        check("reset_in_ready", 128'(in_ready), 128'(1));
        @(posedge clk);
        #1;

        // Test 1: accept into port1
        drive(1, 2'b01, va, 3'b000, 0);
        tick("t1");
        check("t1_valid_lit", 128'(out_valid), 128'(3'b010));
        check("t1_data1_lit", 128'(out_data1), 128'({32'h11, 32'h22, 32'h33, 32'h44}));
        check("t1_cnt1_lit", 128'(cnt1), 128'(0));

        // Test 2: port2 full and stalled, then drain+reload on the same edge
        drive(1, 2'b10, vc, 3'b000, 0);
        tick("t2_load");
        drive(1, 2'b11, vb, 3'b000, 0);
        #1;
        check("t2_stall_ready", 128'(in_ready), 128'(0));
        tick("t2_stall");
        check("t2_hold", 128'(out_data2), 128'(vc));
        saved[2] = m_cnt[2];
        drive(1, 2'b11, vb, 3'b100, 0);
        #1;
        check("t2_go_ready", 128'(in_ready), 128'(1));
        tick("t2_swap");
        check("t2_valid2", 128'(out_valid[2]), 128'(1));
        check("t2_data2", 128'(out_data2), 128'(vb));
        check("t2_cnt2", 128'(cnt2), 128'(saved[2] + 1));

        // Test 3: port0 full and stalled does not block a port2 accept
        drive(1, 2'b00, va, 3'b000, 0);
        tick("t3_load0");
        vc = rand_vec();
        drive(1, 2'b10, vc, 3'b100, 0);
        #1;
        check("t3_ready", 128'(in_ready), 128'(1));
        tick("t3_acc2");
        check("t3_data2", 128'(out_data2), 128'(vc));
        check("t3_port0", 128'(out_data0), 128'(va));
        check("t3_valid", 128'(out_valid), 128'(3'b111));

        // Test 5: flush with all ports full
        for (int n = 0; n < 3; n++) saved[n] = m_cnt[n];
        drive(1, 2'b01, rand_vec(), 3'b111, 1);
        #1;
        check("t5_ready", 128'(in_ready), 128'(0));
        tick("t5_flush");
        check("t5_valid", 128'(out_valid), 128'(3'b000));
        check("t5_cnt0", 128'(cnt0), 128'(saved[0]));
        check("t5_cnt2", 128'(cnt2), 128'(saved[2]));
        drive(0, 2'b00, '0, 3'b000, 0);
        tick("t5_after");

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 3) != 0), 2'($urandom), rand_vec(), 3'($urandom),
                  ($urandom_range(0, 19) == 0));
            tick("rnd");
        end

        // Test 6: asynchronous reset pulse between edges
        drive(1, 2'b00, rand_vec(), 3'b000, 0); tick("t6_f0");
        drive(1, 2'b01, rand_vec(), 3'b000, 0); tick("t6_f1");
        drive(1, 2'b10, rand_vec(), 3'b000, 0); tick("t6_f2");
        drive(0, 2'b00, '0, 3'b000, 0);
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("t6_rst");
        check("t6_rst_valid_lit", 128'(out_valid), 128'(3'b000));
        rst_n = 1'b1;
        #1;
        check("t6_ready", 128'(in_ready), 128'(1));
        vb = rand_vec();
        drive(1, 2'b01, vb, 3'b000, 0);
        tick("t6_acc");
        check("t6_acc_valid", 128'(out_valid), 128'(3'b010));
        check("t6_acc_data", 128'(out_data1), 128'(vb));

        // Test 4: stream port0 until its counter is all-ones, then one more transfer wraps it
        guard = 0;
        drive(1, 2'b00, rand_vec(), 3'b001, 0);
        while (m_cnt[0] != 16'hFFFF && guard < 70000) begin
            in_data = rand_vec();
            tick("t4_run");
            guard++;
        end
        check("t4_reach", 128'(cnt0), 128'(16'hFFFF));
        drive(0, 2'b00, '0, 3'b001, 0);
        tick("t4_wrap");
        check("t4_wrap_lit", 128'(cnt0), 128'(16'h0000));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
